// File: rtl/arm_hps_system_switch_in.sv
// Avalon-MM input port for board switches/keys: 2-flop synchronizer, per-bit
// debounce, edge capture (write-1-to-clear), irq mask and a registered level irq.
module arm_hps_system_switch_in #(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Count value on which a persistent mismatch is accepted as the new level.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r          = 32'd0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] deb_s;
   logic [WIDTH-1:0] deb_d_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_cap_r;
   logic             irq_r;

   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] any_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] clr_s;
   logic             mask_we_s;
   logic             wr_s;
   logic             unused_wdata_s;

   assign unused_wdata_s = ^writedata[31:WIDTH];

   // Two-stage synchronizer for the asynchronous pin inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= in_port;
         sync2_r <= sync1_r;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      logic deb_bit_r;
      assign deb_s[i] = deb_bit_r;

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // Debounce bypassed: follow the synchronized level directly.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb_bit_r <= 1'b0;
            end else begin
               deb_bit_r <= sync2_r[i];
            end
         end
      end else begin : g_count
         logic [CNT_WIDTH-1:0] cnt_r;

         // Any return to the current level restarts the stability count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_r     <= '0;
               deb_bit_r <= 1'b0;
            end else if (sync2_r[i] == deb_bit_r) begin
               cnt_r     <= '0;
            end else if (cnt_r == CNT_LAST) begin
               cnt_r     <= '0;
               deb_bit_r <= sync2_r[i];
            end else begin
               cnt_r     <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign rise_s = deb_s & ~deb_d_r;
   assign fall_s = ~deb_s & deb_d_r;
   assign any_s  = deb_s ^ deb_d_r;
   assign wr_s   = chipselect & ~write_n;

   // Select the edge polarity that feeds the capture register.
   always_comb begin
      edge_s = rise_s;
      case (EDGE_TYPE)
         32'sd0:  edge_s = rise_s;
         32'sd1:  edge_s = fall_s;
         32'sd2:  edge_s = any_s;
         default: edge_s = rise_s;
      endcase
   end

   // Decode register writes; data and reserved addresses are not writable.
   always_comb begin
      clr_s     = '0;
      mask_we_s = 1'b0;
      if (wr_s) begin
         case (address)
            ADDR_MASK: mask_we_s = 1'b1;
            ADDR_EDGE: clr_s     = writedata[WIDTH-1:0];
            default: begin
               clr_s     = '0;
               mask_we_s = 1'b0;
            end
         endcase
      end else begin
         clr_s     = '0;
         mask_we_s = 1'b0;
      end
   end

   // Edge history, mask, sticky capture (a new edge beats a clear) and irq.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d_r    <= '0;
         irq_mask_r <= '0;
         edge_cap_r <= '0;
         irq_r      <= 1'b0;
      end else begin
         deb_d_r    <= deb_s;
         edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
         irq_r      <= |(edge_cap_r & irq_mask_r);
         if (mask_we_s) begin
            irq_mask_r <= writedata[WIDTH-1:0];
         end else begin
            irq_mask_r <= irq_mask_r;
         end
      end
   end

   // Zero-latency read mux; reads have no side effects.
   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA: readdata = zext(deb_s);
         ADDR_RSVD: readdata = 32'd0;
         ADDR_MASK: readdata = zext(irq_mask_r);
         ADDR_EDGE: readdata = zext(edge_cap_r);
         default:   readdata = 32'd0;
      endcase
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_arm_hps_system_switch_in.sv
// Directed bench for arm_hps_system_switch_in with DEBOUNCE_CYCLES=4, WIDTH=10,
// rising-edge capture: table of register vectors plus timed debounce/irq sequences.
module tb_arm_hps_system_switch_in;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  in_port;
   logic        irq;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic        do_wr;
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  raddr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [7];

   arm_hps_system_switch_in #(
      .WIDTH(10),
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH(16),
      .EDGE_TYPE(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(nm, d, exp);
   endtask

   task automatic chk_irq(input string nm, input logic exp);
      chk(nm, {31'd0, irq}, {31'd0, exp});
   endtask

   // Write issued at a falling edge, takes effect on the next rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   initial begin
      logic [31:0] d;
      logic        low_seen;
      n_cmp = 0;
      n_bad = 0;

      vecs[0] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_03FF, 1'b0};
      vecs[1] = '{1'b1, 2'd2, 32'h0000_0155, 2'd2, 32'h0000_0155, 1'b0};
      vecs[2] = '{1'b1, 2'd0, 32'h0000_02AA, 2'd0, 32'h0000_0000, 1'b0};
      vecs[3] = '{1'b1, 2'd1, 32'h0000_03FF, 2'd1, 32'h0000_0000, 1'b0};
      vecs[4] = '{1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_0155, 1'b0};
      vecs[5] = '{1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h0000_0000, 1'b0};
      vecs[6] = '{1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_0000, 1'b0};

      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 10'h3FF;

      // Reset state with all inputs high.
      ticks(3);
      for (int a = 0; a < 4; a++) chk_rd($sformatf("reset_rd_a%0d", a), 2'(a), 32'd0);
      chk_irq("reset_irq", 1'b0);

      // Release: deb follows after 2+4 edges, capture one edge later.
      reset_n = 1'b1;
      ticks(5);
      chk_rd("init_deb_before", 2'd0, 32'h000);
      tick();
      chk_rd("init_deb", 2'd0, 32'h3FF);
      chk_rd("init_cap_before", 2'd3, 32'h000);
      tick();
      chk_rd("init_cap", 2'd3, 32'h3FF);
      chk_irq("init_irq_masked", 1'b0);

      in_port = 10'h000;
      ticks(8);
      wr(2'd3, 32'h3FF);
      chk_rd("init_clear", 2'd3, 32'h000);

      // Register-level vectors with quiet inputs.
      foreach (vecs[i]) begin
         if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
         else tick();
         rd(vecs[i].raddr, d);
         chk($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
         chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      end

      // Bouncing input: deb settles 6 edges after the final transition.
      in_port[0] = 1'b1; tick();
      in_port[0] = 1'b0; tick();
      in_port[0] = 1'b1;
      ticks(5);
      chk_rd("bounce_deb_early", 2'd0, 32'h000);
      tick();
      chk_rd("bounce_deb", 2'd0, 32'h001);
      tick();
      chk_rd("bounce_cap", 2'd3, 32'h001);
      ticks(3);
      chk_rd("bounce_cap_hold", 2'd3, 32'h001);

      // Three-cycle low pulse is filtered out.
      wr(2'd3, 32'h001);
      address    = 2'd0;
      in_port[0] = 1'b0;
      ticks(3);
      in_port[0] = 1'b1;
      low_seen   = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         rd(2'd0, d);
         if (d[0] == 1'b0) low_seen = 1'b1;
      end
      chk("pulse_deb_low_seen", {31'd0, low_seen}, 32'd0);
      chk_rd("pulse_no_cap", 2'd3, 32'h000);

      // Capture and irq timing.
      wr(2'd3, 32'h3FF);
      wr(2'd2, 32'h001);
      in_port[0] = 1'b0;
      ticks(8);
      chk_rd("irq_pre_cap", 2'd3, 32'h000);
      chk_irq("irq_pre", 1'b0);
      in_port[0] = 1'b1;
      ticks(7);
      chk_rd("irq_cap", 2'd3, 32'h001);
      chk_irq("irq_same_cycle", 1'b0);
      tick();
      chk_irq("irq_assert", 1'b1);
      wr(2'd3, 32'h001);
      chk_rd("irq_clr_cap", 2'd3, 32'h000);
      chk_irq("irq_clr_lag", 1'b1);
      tick();
      chk_irq("irq_deassert", 1'b0);

      // Masked capture does not raise irq until unmasked.
      in_port[5] = 1'b1;
      ticks(7);
      chk_rd("mask_cap", 2'd3, 32'h020);
      ticks(2);
      chk_irq("mask_irq_off", 1'b0);
      wr(2'd2, 32'h020);
      chk_irq("mask_irq_lag", 1'b0);
      tick();
      chk_irq("mask_irq_on", 1'b1);

      // Set/clear collision on bit0: the new edge wins.
      wr(2'd3, 32'h3FF);
      wr(2'd2, 32'h001);
      tick();
      chk_irq("coll_irq_idle", 1'b0);
      in_port[0] = 1'b0;
      ticks(8);
      in_port[0] = 1'b1;
      ticks(9);
      chk_rd("coll_cap_first", 2'd3, 32'h001);
      chk_irq("coll_irq_first", 1'b1);
      in_port[0] = 1'b0;
      ticks(8);
      chk_rd("coll_cap_fall", 2'd3, 32'h001);
      in_port[0] = 1'b1;
      ticks(6);
      wr(2'd3, 32'h001);
      chk_rd("coll_cap", 2'd3, 32'h001);
      chk_irq("coll_irq", 1'b1);
      tick();
      chk_rd("coll_cap_after", 2'd3, 32'h001);
      chk_irq("coll_irq_after", 1'b1);

      // Reset mid-operation with counters running.
      in_port = 10'h000;
      ticks(8);
      wr(2'd2, 32'h3FF);
      wr(2'd3, 32'h3FF);
      in_port = 10'h3FF;
      ticks(7);
      chk_rd("mid_cap", 2'd3, 32'h3FF);
      tick();
      chk_irq("mid_irq", 1'b1);
      in_port[3] = 1'b0;
      ticks(4);
      reset_n = 1'b0;
      #1;
      chk_irq("mid_rst_irq", 1'b0);
      for (int a = 0; a < 4; a++) chk_rd($sformatf("mid_rst_a%0d", a), 2'(a), 32'd0);
      ticks(2);
      reset_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
